// File: rtl/mcu_pipe.sv
// Squared-distance metric |u - h*s|^2 for one candidate per transfer, saturating fixed point.
// Latency 3 cycles, throughput 1/cycle; single global enable stalls all stages when the output is held.
// in_ready_o drops only while a valid metric waits on out_ready_i; bubbles are not collapsed.
module mcu_pipe #(
  parameter int WL        = 18,
  parameter int FRAC      = 10,
  parameter int TAG_W     = 8,
  parameter int COMPLEX_H = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic signed [WL-1:0] u_re_i,
  input  logic signed [WL-1:0] u_im_i,
  input  logic signed [WL-1:0] h_re_i,
  input  logic signed [WL-1:0] h_im_i,
  input  logic signed [WL-1:0] s_re_i,
  input  logic signed [WL-1:0] s_im_i,
  input  logic [TAG_W-1:0]     tag_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [WL-1:0]        metric_o,
  output logic [TAG_W-1:0]     tag_o,
  output logic                 sat_o
);

  localparam int PW = 2*WL + 1;
  localparam int QW = 2*WL + 2;
  localparam logic signed [PW-1:0] HS_MAX = {{(PW-WL+1){1'b0}}, {(WL-1){1'b1}}};
  localparam logic signed [PW-1:0] HS_MIN = {{(PW-WL+1){1'b1}}, {(WL-1){1'b0}}};
  localparam logic [QW-1:0]        SQ_MAX = {{(QW-WL+1){1'b0}}, {(WL-1){1'b1}}};
  localparam logic [WL-1:0]        M_MAX  = {1'b0, {(WL-1){1'b1}}};

  function automatic logic [2*WL-1:0] sx(input logic [WL-1:0] x);
    sx = {{WL{x[WL-1]}}, x};
  endfunction

  // Returns {saturated, value} clamped to the signed WL range.
  function automatic logic [WL:0] sat_hs(input logic signed [PW-1:0] x);
    if (x > HS_MAX)      sat_hs = {1'b1, HS_MAX[WL-1:0]};
    else if (x < HS_MIN) sat_hs = {1'b1, HS_MIN[WL-1:0]};
    else                 sat_hs = {1'b0, x[WL-1:0]};
  endfunction

  function automatic logic [WL:0] sat_sq(input logic [QW-1:0] x);
    if (x > SQ_MAX) sat_sq = {1'b1, M_MAX};
    else            sat_sq = {1'b0, x[WL-1:0]};
  endfunction

  logic en;
  assign en         = !(out_valid_o && !out_ready_i);
  assign in_ready_o = en;

  // S1: complex product h*s
  logic signed [WL-1:0]   h_im_eff;
  logic signed [2*WL-1:0] p_rr, p_ii, p_ri, p_ir;
  logic signed [PW-1:0]   acc_re, acc_im;
  logic [WL:0]            hs_re_s, hs_im_s;
  logic                   inf_in;

  assign h_im_eff = (COMPLEX_H != 0) ? h_im_i : '0;
  assign p_rr     = sx(h_re_i)   * sx(s_re_i);
  assign p_ii     = sx(h_im_eff) * sx(s_im_i);
  assign p_ri     = sx(h_re_i)   * sx(s_im_i);
  assign p_ir     = sx(h_im_eff) * sx(s_re_i);
  assign acc_re   = {p_rr[2*WL-1], p_rr} - {p_ii[2*WL-1], p_ii};
  assign acc_im   = {p_ri[2*WL-1], p_ri} + {p_ir[2*WL-1], p_ir};
  assign hs_re_s  = sat_hs(acc_re >>> FRAC);
  assign hs_im_s  = sat_hs(acc_im >>> FRAC);
  assign inf_in   = (&s_re_i) && (&s_im_i);

  logic                   v1, inf1, sat1;
  logic signed [WL-1:0]   u1_re, u1_im, hs1_re, hs1_im;
  logic [TAG_W-1:0]       tag1;

  // S2: difference widened by one bit so it never wraps, then squared
  logic [WL:0]   d_re, d_im;
  logic [QW-1:0] sq_re_f, sq_im_f;
  logic [WL:0]   sq_re_s, sq_im_s;

  assign d_re    = {u1_re[WL-1], u1_re} - {hs1_re[WL-1], hs1_re};
  assign d_im    = {u1_im[WL-1], u1_im} - {hs1_im[WL-1], hs1_im};
  assign sq_re_f = {{(WL+1){d_re[WL]}}, d_re} * {{(WL+1){d_re[WL]}}, d_re};
  assign sq_im_f = {{(WL+1){d_im[WL]}}, d_im} * {{(WL+1){d_im[WL]}}, d_im};
  assign sq_re_s = sat_sq(sq_re_f >> FRAC);
  assign sq_im_s = sat_sq(sq_im_f >> FRAC);

  logic                   v2, inf2, sat2;
  logic [WL-1:0]          sq2_re, sq2_im;
  logic [TAG_W-1:0]       tag2;

  // S3: sum of squares
  logic [WL:0] sum;
  logic        sum_sat;

  assign sum     = {1'b0, sq2_re} + {1'b0, sq2_im};
  assign sum_sat = sum > {1'b0, M_MAX};

  always_ff @(posedge clk) begin
    if (rst) begin
      v1          <= 1'b0;
      v2          <= 1'b0;
      out_valid_o <= 1'b0;
      metric_o    <= '0;
      tag_o       <= '0;
      sat_o       <= 1'b0;
    end else if (en) begin
      v1          <= in_valid_i;
      v2          <= v1;
      out_valid_o <= v2;
      if (v2) begin
        tag_o <= tag2;
        if (inf2) begin
          metric_o <= M_MAX;
          sat_o    <= 1'b0;
        end else begin
          metric_o <= sum_sat ? M_MAX : sum[WL-1:0];
          sat_o    <= sat2 | sum_sat;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (en && in_valid_i) begin
      u1_re  <= u_re_i;
      u1_im  <= u_im_i;
      hs1_re <= hs_re_s[WL-1:0];
      hs1_im <= hs_im_s[WL-1:0];
      tag1   <= tag_i;
      inf1   <= inf_in;
      sat1   <= hs_re_s[WL] | hs_im_s[WL];
    end
    if (en && v1) begin
      sq2_re <= sq_re_s[WL-1:0];
      sq2_im <= sq_im_s[WL-1:0];
      tag2   <= tag1;
      inf2   <= inf1;
      sat2   <= sat1 | sq_re_s[WL] | sq_im_s[WL];
    end
  end

endmodule

// File: tb/tb_mcu_pipe.sv
// Scoreboard bench for mcu_pipe: complex and real-channel instances share stimulus, each with its own queue.
module tb_mcu_pipe;

  localparam longint MAXV = 131071;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b1;
  logic signed [17:0] u_re = '0, u_im = '0, h_re = '0, h_im = '0, s_re = '0, s_im = '0;
  logic [7:0] tag = '0;

  logic rdy1, ovld1, sat1, rdy0, ovld0, sat0;
  logic [17:0] met1, met0;
  logic [7:0]  tag1_o, tag0_o;

  typedef struct packed {
    logic [17:0] m;
    logic [7:0]  t;
    logic        s;
  } exp_t;

  exp_t q1[$];
  exp_t q0[$];
  int   nchk = 0;
  int   nerr = 0;
  bit   rdy_rand = 1'b0;

  always #5 clk = ~clk;

  mcu_pipe #(.WL(18), .FRAC(10), .TAG_W(8), .COMPLEX_H(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy1),
    .u_re_i(u_re), .u_im_i(u_im), .h_re_i(h_re), .h_im_i(h_im),
    .s_re_i(s_re), .s_im_i(s_im), .tag_i(tag),
    .out_valid_o(ovld1), .out_ready_i(out_ready),
    .metric_o(met1), .tag_o(tag1_o), .sat_o(sat1)
  );

  mcu_pipe #(.WL(18), .FRAC(10), .TAG_W(8), .COMPLEX_H(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(rdy0),
    .u_re_i(u_re), .u_im_i(u_im), .h_re_i(h_re), .h_im_i(h_im),
    .s_re_i(s_re), .s_im_i(s_im), .tag_i(tag),
    .out_valid_o(ovld0), .out_ready_i(out_ready),
    .metric_o(met0), .tag_o(tag0_o), .sat_o(sat0)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: direct evaluation of the metric with wide integers, saturating at each step.
  function automatic logic [18:0] model(input longint ur, ui, hr, hi, sr, si, input bit cplx);
    longint hie, pr, pi, dr, di, qr, qi, m;
    bit s;
    if (sr == -1 && si == -1) return {1'b0, 18'h1FFFF};
    s   = 1'b0;
    hie = cplx ? hi : 0;
    pr  = (hr * sr - hie * si) >>> 10;
    pi  = (hr * si + hie * sr) >>> 10;
    if (pr > MAXV) begin pr = MAXV; s = 1'b1; end
    else if (pr < -MAXV - 1) begin pr = -MAXV - 1; s = 1'b1; end
    if (pi > MAXV) begin pi = MAXV; s = 1'b1; end
    else if (pi < -MAXV - 1) begin pi = -MAXV - 1; s = 1'b1; end
    dr = ur - pr;
    di = ui - pi;
    qr = (dr * dr) / 1024;
    qi = (di * di) / 1024;
    if (qr > MAXV) begin qr = MAXV; s = 1'b1; end
    if (qi > MAXV) begin qi = MAXV; s = 1'b1; end
    m = qr + qi;
    if (m > MAXV) begin m = MAXV; s = 1'b1; end
    return {s, m[17:0]};
  endfunction

  function automatic logic signed [17:0] rv();
    int t;
    logic signed [17:0] r;
    case ($urandom_range(0, 3))
      0: begin t = $urandom_range(0, 4095) - 2048; r = t[17:0]; end
      1: begin t = $urandom; r = t[17:0]; end
      2: r = ($urandom_range(0, 1) == 1) ? 18'sh1FFFF : 18'sh20000;
      default: begin t = $urandom_range(0, 16383) - 8192; r = t[17:0]; end
    endcase
    return r;
  endfunction

  task automatic upd_rdy();
    if (rdy_rand) out_ready = ($urandom_range(0, 9) < 7);
  endtask

  task automatic put(input bit vld, input logic signed [17:0] ur, ui, hr, hi, sr, si,
                     input logic [7:0] tg);
    in_valid = vld;
    u_re = ur; u_im = ui; h_re = hr; h_im = hi; s_re = sr; s_im = si;
    tag = tg;
  endtask

  task automatic push2(input logic [7:0] tg, input logic [18:0] x1, input logic [18:0] x0);
    exp_t e;
    e.t = tg;
    e.m = x1[17:0]; e.s = x1[18]; q1.push_back(e);
    e.m = x0[17:0]; e.s = x0[18]; q0.push_back(e);
  endtask

  // Presents one item until accepted; x1/x0 are {sat, metric} for the complex/real instances.
  task automatic send(input logic signed [17:0] ur, ui, hr, hi, sr, si, input logic [7:0] tg,
                      input logic [18:0] x1, input logic [18:0] x0);
    int tries = 0;
    forever begin
      @(negedge clk);
      upd_rdy();
      put(1'b1, ur, ui, hr, hi, sr, si, tg);
      #1;
      if (rdy1) begin
        push2(tg, x1, x0);
        break;
      end
      tries++;
      if (tries > 500) begin
        chk("send_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic send_m(input logic signed [17:0] ur, ui, hr, hi, sr, si, input logic [7:0] tg);
    send(ur, ui, hr, hi, sr, si, tg, model(ur, ui, hr, hi, sr, si, 1'b1),
         model(ur, ui, hr, hi, sr, si, 1'b0));
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      upd_rdy();
      put(1'b0, rv(), rv(), rv(), rv(), rv(), rv(), 8'($urandom));
    end
  endtask

  // Monitor: pops and compares on every output transfer.
  always begin
    exp_t e;
    @(negedge clk);
    #2;
    if (!rst && ovld1 && out_ready) begin
      if (q1.size() == 0) chk("cplx_unexpected_out", tag1_o, 9999);
      else begin
        e = q1.pop_front();
        chk("cplx_metric", met1, e.m);
        chk("cplx_tag", tag1_o, e.t);
        chk("cplx_sat", sat1, e.s);
      end
    end
    if (!rst && ovld0 && out_ready) begin
      if (q0.size() == 0) chk("real_unexpected_out", tag0_o, 9999);
      else begin
        e = q0.pop_front();
        chk("real_metric", met0, e.m);
        chk("real_tag", tag0_o, e.t);
        chk("real_sat", sat0, e.s);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    nerr++;
    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $fatal(1, "watchdog");
  end

  initial begin
    int idx;
    int waited;
    logic signed [17:0] a, b;

    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", ovld1, 0);
    chk("rst_metric", met1, 0);
    chk("rst_tag", tag1_o, 0);
    chk("rst_sat", sat1, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", rdy1, 1);

    // Real path with latency check
    send(2048, 0, 1024, 0, 1024, 0, 8'h11, {1'b0, 18'd1024}, {1'b0, 18'd1024});
    idle(1);
    idle(1);
    #1;
    chk("latency_not_early", ovld1, 0);
    idle(1);
    #1;
    chk("latency_3", ovld1, 1);
    chk("real_path_metric", met0, 1024);

    send(0, 1024, 512, 512, 1024, 1024, 8'h22, {1'b0, 18'd0}, {1'b0, 18'd512});
    a = rv(); b = rv();
    send(a, b, rv(), rv(), 18'sh3FFFF, 18'sh3FFFF, 8'h33, {1'b0, 18'd131071}, {1'b0, 18'd131071});
    send(130048, 0, 0, 0, 0, 0, 8'h44, {1'b1, 18'd131071}, {1'b1, 18'd131071});
    send(-131072, -131072, 0, 0, 0, 0, 8'h55, {1'b1, 18'd131071}, {1'b1, 18'd131071});
    idle(6);

    // Back-pressure: only three fit while the output is held
    idx = 1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      out_ready = 1'b0;
      a = rv(); b = rv();
      put(1'b1, a, b, 512, -256, 1024, 300, 8'(idx));
      #1;
      if (c == 3) chk("bp_ready_low", rdy1, 0);
      if (rdy1) begin
        push2(8'(idx), model(a, b, 512, -256, 1024, 300, 1'b1), model(a, b, 512, -256, 1024, 300, 1'b0));
        idx++;
      end
    end
    in_valid = 1'b0;
    chk("bp_accepted", idx - 1, 3);
    out_ready = 1'b1;
    while (idx <= 5) begin
      send_m(rv(), rv(), 700, 100, -900, 50, 8'(idx));
      idx++;
    end
    idle(8);
    chk("bp_drained", q1.size(), 0);

    // Reset with three items in flight
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) send_m(rv(), rv(), rv(), rv(), rv(), rv(), 8'(8'hA0 + k));
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    q1.delete();
    q0.delete();
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrst_out_valid", ovld1, 0);
    chk("midrst_metric", met1, 0);
    chk("midrst_ready", rdy1, 1);
    out_ready = 1'b1;
    idle(8);
    chk("midrst_no_stale", ovld1, 0);

    // Randomized traffic with random back-pressure
    rdy_rand = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 15) == 0)
        send_m(rv(), rv(), rv(), rv(), 18'sh3FFFF, 18'sh3FFFF, 8'($urandom));
      else
        send_m(rv(), rv(), rv(), rv(), rv(), rv(), 8'($urandom));
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
    rdy_rand = 1'b0;
    out_ready = 1'b1;
    waited = 0;
    while ((q1.size() != 0 || q0.size() != 0) && waited < 200) begin
      idle(1);
      waited++;
    end
    idle(2);
    chk("final_q_cplx_empty", q1.size(), 0);
    chk("final_q_real_empty", q0.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
